// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: multi-cycle signed multiplier using a radix-2 Booth
// shift-add loop. An operand pair is accepted in IDLE or DONE. WIDTH
// iterations follow, each one presenting an add/subtract pair to a single
// (WIDTH+1)-bit adder. A one-cycle done pulse then marks the product.
// Optional feature macro: SHIFT_ADD_MULT_ZERO_SKIP_EN. When it is defined,
// a zero operand completes directly in DONE with a product of 0.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH:0]  acc;     // Booth accumulator, one guard bit wider than the operands
  logic [WIDTH:0]  m;       // sign-extended multiplicand
  logic [WIDTH-1:0] q;      // multiplier; product low half shifts in here
  logic            q_prev;
  logic [CW-1:0]   count;

  logic [WIDTH:0]  addend;
  logic            cin;
  logic [WIDTH:0]  sum;

  // Booth recode of {q[0], q_prev} into the operand pair for the shared adder.
  // Subtraction is formed as acc + ~m + 1.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    addend = '0;
    cin    = 1'b0;
    case ({q[0], q_prev})
      2'b01:   addend = m;
      2'b10: begin
        addend = ~m;
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
    sum = acc + addend + {{WIDTH{1'b0}}, cin};
  end

  // Control FSM and datapath: load on accept, one Booth step per BUSY cycle,
  // and registered busy/done/product outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      q_prev  <= 1'b0;
      count   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // right-hand side reads the value from before the edge.
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m      <= {a[WIDTH-1], a};
            acc    <= '0;
            q      <= b;
            q_prev <= 1'b0;
            count  <= CW'(WIDTH - 1);
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
            if (a == '0 || b == '0) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              product <= '0;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
            end
`else
            state <= BUSY;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        BUSY: begin
          // Arithmetic right shift of {sum, q, q_prev} by one bit.
          acc    <= {sum[WIDTH], sum[WIDTH:1]};
          q      <= {sum[0], q[WIDTH-1:1]};
          q_prev <= q[0];
          if (count == '0) begin
            // Low 2*WIDTH bits of the shifted {acc, q}.
            product <= {sum, q[WIDTH-1:1]};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            count <= count - CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: self-checking bench for shift_add_multiplier with
// WIDTH=8. It covers a table of directed operand pairs, sequences for
// back-to-back operation, start while busy and reset mid-operation, and a
// randomized sweep that is compared against signed integer multiplication.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[7];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses on the falling edge, away from the active edge.
  always @(negedge clk) if (done === 1'b1) n_done++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the exact signed product, reduced to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[2*W-1:0];
  endfunction

  function automatic bit zero_skip(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
    return (x == '0 || y == '0);
`else
    return (x == '0 && y == '0 && 1'b0);
`endif
  endfunction

  // Apply a single one-cycle start pulse. Check the latency, the busy cycles,
  // the product, that done lasts one cycle, and that the product is held.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input string tag, output logic [2*W-1:0] got);
    int lat, busy_cyc, exp_lat, exp_busy, n0;
    bit seen;
    logic [2*W-1:0] exp_p;
    exp_p    = model(ai, bi);
    exp_lat  = zero_skip(ai, bi) ? 1 : W + 1;
    exp_busy = zero_skip(ai, bi) ? 0 : W;
    n0 = n_done;
    start = 1'b1; a = ai; b = bi;
    lat = 0; busy_cyc = 0; seen = 1'b0; got = '0;
    for (int c = 0; c < 4 * W; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat++;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        got  = product;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    check({tag, "_product"}, 32'(got), 32'(exp_p));
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_product_hold"}, 32'(product), 32'(exp_p));
    check({tag, "_done_count"}, n_done - n0, 1);
  endtask

  initial begin
    logic [2*W-1:0] got;
    logic [W-1:0]   ba[3];
    logic [W-1:0]   bb[3];
    logic [2*W-1:0] bp[3];
    int k, cyc, last, n0, done_cyc;
    logic [2*W-1:0] cap;

    vecs[0] = '{a: 8'd7,    b: 8'hFD,  p: 16'hFFEB};
    vecs[1] = '{a: 8'h80,   b: 8'h80,  p: 16'h4000};
    vecs[2] = '{a: 8'h80,   b: 8'h7F,  p: 16'hC080};
    vecs[3] = '{a: 8'h7F,   b: 8'h7F,  p: 16'h3F01};
    vecs[4] = '{a: 8'd3,    b: 8'hFC,  p: 16'hFFF4};
    vecs[5] = '{a: 8'd5,    b: 8'd5,   p: 16'd25};
    vecs[6] = '{a: 8'd0,    b: 8'hB3,  p: 16'h0000};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle_busy", 32'(busy), 32'd0);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), got);
      check($sformatf("vec%0d_table", i), 32'(got), 32'(vecs[i].p));
    end
    repeat (3) @(posedge clk);
    #1;
    check("idle_product_hold", 32'(product), 32'h0);

    // Back-to-back corner operands with start held high.
    ba[0] = 8'h80; bb[0] = 8'h80; bp[0] = 16'h4000;
    ba[1] = 8'h80; bb[1] = 8'h7F; bp[1] = 16'hC080;
    ba[2] = 8'h7F; bb[2] = 8'h7F; bp[2] = 16'h3F01;
    n0 = n_done;
    start = 1'b1; a = ba[0]; b = bb[0];
    k = 0; cyc = 0; last = 0;
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        check($sformatf("b2b%0d_product", k), 32'(product), 32'(bp[k]));
        check($sformatf("b2b%0d_spacing", k), cyc - last, W + 1);
        last = cyc;
        k++;
        if (k < 3) begin
          a = ba[k]; b = bb[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_results", k, 3);
    @(posedge clk); #1;
    check("b2b_done_count", n_done - n0, 3);

    // start re-pulsed on the third BUSY cycle is ignored.
    n0 = n_done; done_cyc = 0; cap = '0;
    start = 1'b1; a = 8'd5; b = 8'd5;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 3) begin start = 1'b1; a = 8'd2; b = 8'd2; end
      if (c == 4) start = 1'b0;
      if (done && done_cyc == 0) begin done_cyc = c; cap = product; end
    end
    check("ignore_start_latency", done_cyc, W + 1);
    check("ignore_start_product", 32'(cap), 32'd25);
    check("ignore_start_done_count", n_done - n0, 1);
    check("ignore_start_hold", 32'(product), 32'd25);

    // Reset on the fourth BUSY cycle aborts the operation.
    n0 = n_done;
    start = 1'b1; a = 8'd9; b = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("abort_no_done", n_done - n0, 0);
    @(posedge clk); #1;
    run_op(8'd3, 8'hFC, "after_abort", got);
    check("after_abort_table", 32'(got), 32'hFFF4);

    // Randomized sweep against the reference model.
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 97 == 0) ra = '0;
      run_op(ra, rb, "rand", got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
